// File: rtl/right_shifter_sticky_pipe.sv
// Two-stage pipelined logical right shifter with guard and sticky outputs.
//
// Stage 1 resolves the high shift bits i_s[clog2(N):SPLIT] and registers the
// partial result plus a partial guard and sticky. Stage 2 resolves the low
// bits i_s[SPLIT-1:0] and registers the final result. Each stage has a valid
// flag, and a valid/ready handshake runs at both ends.
//
// Parameters:
//   N      data width (a power of two, at least 4)
//   SPLIT  number of low shift bits resolved in stage 2 (1..clog2(N))
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_valid, o_ready   operand handshake
//   i_in, i_s          data to shift and shift amount (0..2N-1)
//   i_padbit           value shifted in at the MSB
//   o_valid, i_ready   result handshake
//   o_r                shifted result
//   o_guard            last input bit shifted out
//   o_sticky           OR of every input bit shifted out
//
// Build option: define RIGHT_SHIFTER_STICKY_PIPE_STICKY_EN to implement
// o_sticky. When it is undefined the sticky logic is removed and o_sticky is 0.

module right_shifter_sticky_pipe #(
  parameter int unsigned N     = 16,
  parameter int unsigned SPLIT = $clog2(N) / 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [N-1:0]         i_in,
  input  logic [$clog2(N):0]   i_s,
  input  logic                 i_padbit,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [N-1:0]         o_r,
  output logic                 o_guard,
  output logic                 o_sticky
);

  localparam int unsigned SW = $clog2(N);

  // Handshake.
  logic v1_q, v2_q;
  logic ld1, ld2, acc1;

  assign ld2     = !v2_q || i_ready;
  assign ld1     = !v1_q || ld2;
  assign acc1    = i_valid && ld1;
  assign o_ready = ld1;
  assign o_valid = v2_q;

  // Stage 1: coarse shift by the high shift bits (low SPLIT bits forced to 0).
  logic [SW:0]      amt1;
  logic [N-1:0]     r1_d, r1_q;
  logic             g1_d, g1_q;
  logic             pad1_q;
  logic [SPLIT-1:0] amt2_q;

  assign amt1 = {i_s[SW:SPLIT], {SPLIT{1'b0}}};

  // A shift of N or more leaves nothing but pad bits.
  assign r1_d = amt1[SW] ? {N{i_padbit}} : N'({{N{i_padbit}}, i_in} >> amt1);

  // Bit 0 of {in, 0} >> amt is in[amt-1], or 0 for amt = 0. Past N the last
  // bit shifted out is a pad bit.
  assign g1_d = (amt1[SW] && (|amt1[SW-1:0])) ? i_padbit : 1'(({i_in, 1'b0}) >> amt1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q   <= 1'b0;
      r1_q   <= '0;
      g1_q   <= 1'b0;
      pad1_q <= 1'b0;
      amt2_q <= '0;
    end else begin
      if (ld1) v1_q <= i_valid;
      if (acc1) begin
        r1_q   <= r1_d;
        g1_q   <= g1_d;
        pad1_q <= i_padbit;
        amt2_q <= i_s[SPLIT-1:0];
      end
    end
  end

  // Stage 2: fine shift by the low shift bits.
  logic [N-1:0] r2_d, r2_q;
  logic         g2_d, g2_q;

  assign r2_d = N'({{N{pad1_q}}, r1_q} >> amt2_q);
  // Same guard trick as stage 1: with no further shift the stage-1 guard stands.
  assign g2_d = 1'({r1_q, g1_q} >> amt2_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v2_q <= 1'b0;
      r2_q <= '0;
      g2_q <= 1'b0;
    end else begin
      if (ld2) v2_q <= v1_q;
      if (ld2 && v1_q) begin
        r2_q <= r2_d;
        g2_q <= g2_d;
      end
    end
  end

  assign o_r     = r2_q;
  assign o_guard = g2_q;

`ifdef RIGHT_SHIFTER_STICKY_PIPE_STICKY_EN
  localparam logic [2*N-1:0] One2 = {{(2*N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]   OneN = {{(N-1){1'b0}}, 1'b1};

  // Stage 1 also keeps the zero-filled shifted data, so that stage 2 can OR in
  // the real input bits it drops without counting pad bits.
  logic         st1_d, st1_q;
  logic [N-1:0] z1_d, z1_q;
  logic         st2_d, st2_q;

  assign st1_d = |(i_in & N'((One2 << amt1) - One2));
  assign z1_d  = i_in >> amt1;
  assign st2_d = st1_q || (|(z1_q & N'((OneN << amt2_q) - OneN)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st1_q <= 1'b0;
      z1_q  <= '0;
      st2_q <= 1'b0;
    end else begin
      if (acc1) begin
        st1_q <= st1_d;
        z1_q  <= z1_d;
      end
      if (ld2 && v1_q) st2_q <= st2_d;
    end
  end

  assign o_sticky = st2_q;
`else
  assign o_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_right_shifter_sticky_pipe.sv
// Directed bench for right_shifter_sticky_pipe (N=16, SPLIT=2).
module tb_right_shifter_sticky_pipe;

  localparam int NV = 18;
`ifdef RIGHT_SHIFTER_STICKY_PIPE_STICKY_EN
  localparam bit StickyEn = 1'b1;
`else
  localparam bit StickyEn = 1'b0;
`endif

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_in;
  logic [4:0]  i_s;
  logic        i_padbit;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_r;
  logic        o_guard;
  logic        o_sticky;

  right_shifter_sticky_pipe #(
    .N     (16),
    .SPLIT (2)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_in     (i_in),
    .i_s      (i_s),
    .i_padbit (i_padbit),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_r      (o_r),
    .o_guard  (o_guard),
    .o_sticky (o_sticky)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Hand-computed vectors: input, shift, pad -> result, guard, sticky.
  logic [15:0] t_in  [NV] = '{16'hB5A3, 16'hB5A3, 16'h8001, 16'h0000, 16'hB5A3, 16'hB5A3,
                              16'hB5A3, 16'h0100, 16'h0080, 16'h0040, 16'h8000, 16'h8000,
                              16'h0001, 16'h1234, 16'h1234, 16'hFFFF, 16'h7FFF, 16'h0000};
  logic [4:0]  t_s   [NV] = '{5'd4, 5'd0, 5'd16, 5'd20, 5'd1, 5'd7, 5'd15, 5'd8, 5'd8, 5'd8,
                              5'd17, 5'd31, 5'd16, 5'd2, 5'd3, 5'd12, 5'd16, 5'd5};
  logic        t_pad [NV] = '{0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1};
  logic [15:0] t_r   [NV] = '{16'h0B5A, 16'hB5A3, 16'hFFFF, 16'hFFFF, 16'hDAD1, 16'h016B,
                              16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF,
                              16'h0000, 16'hC48D, 16'h0246, 16'h000F, 16'h0000, 16'hF800};
  logic        t_g   [NV] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0};
  logic        t_st  [NV] = '{1, 0, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 0};

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int rx_cnt = 0;
  int acc_cnt = 0;
  bit hold_pend = 1'b0;
  logic [15:0] hold_r;
  logic        hold_g;
  logic        hold_st;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: set i_ready, check the result visible this cycle, then offer
  // operand idx (if v) for the coming edge.
  task automatic step(input bit v, input int idx, input bit rdy, output bit acc, output bit rs);
    int e;
    @(negedge i_clk);
    i_ready = rdy;
    #1;
    if (hold_pend) begin
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_r", 32'(o_r), 32'(hold_r));
      chk("hold_guard", 32'(o_guard), 32'(hold_g));
      chk("hold_sticky", 32'(o_sticky), 32'(hold_st));
    end
    if (o_valid && rdy) begin
      if (exp_q.size() == 0) begin
        chk("spurious_result", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("r[%0d]", e), 32'(o_r), 32'(t_r[e]));
        chk($sformatf("guard[%0d]", e), 32'(o_guard), 32'(t_g[e]));
        chk($sformatf("sticky[%0d]", e), 32'(o_sticky), 32'(t_st[e] & StickyEn));
        rx_cnt++;
      end
    end
    hold_pend = o_valid && !rdy;
    hold_r    = o_r;
    hold_g    = o_guard;
    hold_st   = o_sticky;
    rs  = o_ready;
    acc = v && o_ready;
    i_valid = v;
    if (v) begin
      i_in     = t_in[idx];
      i_s      = t_s[idx];
      i_padbit = t_pad[idx];
    end else begin
      i_in     = 16'hDEAD;
      i_s      = 5'h1F;
      i_padbit = 1'b1;
    end
    if (acc) begin
      exp_q.push_back(idx);
      acc_cnt++;
    end
  endtask

  initial begin
    bit a;
    bit rs;
    int nxt;
    i_rst_n  = 1'b1;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_in     = '0;
    i_s      = '0;
    i_padbit = 1'b0;
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_r", 32'(o_r), 32'd0);
    chk("rst_guard", 32'(o_guard), 32'd0);
    chk("rst_sticky", 32'(o_sticky), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    // Latency: result visible exactly two edges after transfer.
    step(1'b1, 0, 1'b1, a, rs);
    chk("lat_accept", 32'(a), 32'd1);
    step(1'b0, 0, 1'b1, a, rs);
    chk("lat_rx_early", 32'(rx_cnt), 32'd0);
    step(1'b0, 0, 1'b1, a, rs);
    chk("lat_rx", 32'(rx_cnt), 32'd1);

    // Eight back-to-back operands with i_ready held high.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, i, 1'b1, a, rs);
      chk("b2b_ready", 32'(rs), 32'd1);
    end
    step(1'b0, 0, 1'b1, a, rs);
    step(1'b0, 0, 1'b1, a, rs);
    chk("b2b_rx", 32'(rx_cnt), 32'd9);

    // Backpressure: two accepts, then o_ready drops while results are held.
    nxt = 9;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, nxt, 1'b0, a, rs);
      chk($sformatf("bp_ready[%0d]", c), 32'(rs), 32'(c < 2));
      if (a) nxt++;
    end
    chk("bp_accepts", 32'(nxt), 32'd11);
    for (int k = 0; k < 40 && rx_cnt < NV; k++) begin
      step(nxt < NV, nxt, 1'b1, a, rs);
      if (a) nxt++;
    end
    chk("drain_rx", 32'(rx_cnt), 32'(NV));
    chk("drain_acc", 32'(acc_cnt), 32'(NV));

    // Reset with both stages full.
    step(1'b1, 0, 1'b0, a, rs);
    step(1'b1, 1, 1'b0, a, rs);
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_r", 32'(o_r), 32'd0);
    chk("midrst_guard", 32'(o_guard), 32'd0);
    exp_q.delete();
    hold_pend = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("postrst_ready", 32'(o_ready), 32'd1);
    nxt = rx_cnt;
    repeat (3) step(1'b0, 0, 1'b1, a, rs);
    chk("postrst_no_stale", 32'(rx_cnt), 32'(nxt));
    step(1'b1, 5, 1'b1, a, rs);
    step(1'b0, 0, 1'b1, a, rs);
    step(1'b0, 0, 1'b1, a, rs);
    chk("postrst_rx", 32'(rx_cnt), 32'(nxt + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
